clk_div_sched: RTL and testbench

Programmable clock-divider controller sharing one divider between two configuration requesters. Each requester proposes a new half-period count over a valid/ready handshake. A round-robin arbiter grants one request at a time, and an FSM applies it only at a half-period boundary, so `oclk` never has a truncated phase. The block also starts and stops the divided clock cleanly, always parking it low.

---
 rtl/clk_div_sched.sv | 131 +++++++++++++
 tb/tb_clk_div_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_sched
// Brief    : Programmable clock divider whose half-period is updated by two
//            round-robin-arbitrated requesters only at half-period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_sched #(
    parameter int               CLK_FREQ   = 50_000_000,
    parameter int               DEFAULT_HZ = 1,
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] DEF_HALF   = CNT_W'((CLK_FREQ / (DEFAULT_HZ * 2)) - 1)
) (
    input  logic             iclk,
    input  logic             reset,
    input  logic             run,
    input  logic             a_valid,
    input  logic [CNT_W-1:0] a_half,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [CNT_W-1:0] b_half,
    output logic             b_ready,
    output logic             oclk,
    output logic             tick,
    output logic [CNT_W-1:0] active_half,
    output logic             pending
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] active_nx;
    logic [CNT_W-1:0] pend_val, pend_nx;
    logic             oclk_nx, tick_nx;
    logic             last_b, last_b_nx;

    logic             a_win, b_win, accept_ok, grant;
    logic [CNT_W-1:0] grant_half, apply_half;
    logic             apply_en, running, tc, stop_now;

    // Ties go to whichever requester was not granted last.
    assign a_win      = a_valid && (!b_valid || last_b);
    assign b_win      = b_valid && !a_win;
    assign accept_ok  = (state != ST_PEND);
    assign a_ready    = accept_ok && a_win;
    assign b_ready    = accept_ok && b_win;
    assign grant      = a_ready || b_ready;
    assign grant_half = a_ready ? a_half : b_half;
    assign last_b_nx  = grant ? b_ready : last_b;

    assign running  = (state != ST_STOP);
    assign tc       = running && (cnt >= active_half);
    // A low clock can be parked at once; a high one must finish its phase.
    assign stop_now = running && !run && !oclk;

    // Value to commit when leaving for STOP: a held pending value or a same-cycle grant.
    assign apply_en   = (state == ST_PEND) || grant;
    assign apply_half = (state == ST_PEND) ? pend_val : grant_half;

    assign pending = (state == ST_PEND);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        active_nx = active_half;
        pend_nx   = pend_val;
        oclk_nx   = oclk;
        tick_nx   = 1'b0;
        case (state)
            ST_STOP: begin
                cnt_nx = '0;
                if (grant) active_nx = grant_half;
                if (run)   state_nx  = ST_RUN;
            end
            default: begin
                if (stop_now) begin
                    cnt_nx   = '0;
                    state_nx = ST_STOP;
                    if (apply_en) active_nx = apply_half;
                end else if (tc) begin
                    cnt_nx  = '0;
                    oclk_nx = !oclk;
                    tick_nx = 1'b1;
                    if (!run) begin
                        state_nx = ST_STOP;
                        if (apply_en) active_nx = apply_half;
                    end else if (state == ST_PEND) begin
                        active_nx = pend_val;
                        state_nx  = ST_RUN;
                    end else if (grant) begin
                        pend_nx  = grant_half;
                        state_nx = ST_PEND;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                    if (grant) begin
                        pend_nx  = grant_half;
                        state_nx = ST_PEND;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (reset) begin
            state       <= ST_STOP;
            cnt         <= '0;
            oclk        <= 1'b0;
            tick        <= 1'b0;
            active_half <= DEF_HALF;
            pend_val    <= '0;
            last_b      <= 1'b1;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            oclk        <= oclk_nx;
            tick        <= tick_nx;
            active_half <= active_nx;
            pend_val    <= pend_nx;
            last_b      <= last_b_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_sched
// Brief    : Self-checking bench for clk_div_sched (table, directed, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_sched;

    localparam int CW = 8;

    logic          iclk = 1'b0;
    logic          reset, run, a_valid, b_valid;
    logic [CW-1:0] a_half, b_half;
    logic          a_ready, b_ready, oclk, tick, pending;
    logic [CW-1:0] active_half;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_sched #(
        .CLK_FREQ   (20),
        .DEFAULT_HZ (1),
        .CNT_W      (CW)
    ) dut (
        .iclk        (iclk),
        .reset       (reset),
        .run         (run),
        .a_valid     (a_valid),
        .a_half      (a_half),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_half      (b_half),
        .b_ready     (b_ready),
        .oclk        (oclk),
        .tick        (tick),
        .active_half (active_half),
        .pending     (pending)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic          av;
        logic [CW-1:0] ah;
        logic          bv;
        logic [CW-1:0] bh;
        logic          exp_ar;
        logic          exp_br;
        logic [CW-1:0] exp_active;
    } vec_t;

    vec_t vecs[6];

    // Behavioural reference: divider described as mode, phase counter and pending slot.
    bit m_run_mode, m_has_pend, m_oclk, m_tick, m_last_b;
    int m_pend, m_cnt, m_active;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        a_half = '0; b_half = '0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic wait_oclk(input logic lvl, output int n, output int stray);
        n = 0; stray = 0;
        do begin
            step();
            n++;
            if (tick === 1'b1 && oclk !== lvl) stray++;
        end while (oclk !== lvl && n < 100);
    endtask

    task automatic model_cycle(input bit r, input bit ga, input bit gb, input int gval);
        bit grant, at_tc, halt_low;
        grant = ga || gb;
        if (!m_run_mode) begin
            m_cnt = 0; m_tick = 0;
            if (grant) m_active = gval;
            m_run_mode = r;
        end else begin
            at_tc    = (m_cnt >= m_active);
            halt_low = !r && !m_oclk;
            if (halt_low || (at_tc && !r)) begin
                if (!halt_low) begin m_oclk = !m_oclk; m_tick = 1; end
                else m_tick = 0;
                m_cnt = 0; m_run_mode = 0;
                if (m_has_pend) m_active = m_pend;
                else if (grant) m_active = gval;
                m_has_pend = 0;
            end else if (at_tc) begin
                m_oclk = !m_oclk; m_tick = 1; m_cnt = 0;
                if (m_has_pend) begin m_active = m_pend; m_has_pend = 0; end
                else if (grant) begin m_has_pend = 1; m_pend = gval; end
            end else begin
                m_tick = 0; m_cnt++;
                if (grant) begin m_has_pend = 1; m_pend = gval; end
            end
        end
        if (grant) m_last_b = gb;
    endtask

    initial begin
        int n, n2, stray, viol;
        bit ga, gb;
        int gval;

        vecs[0] = '{1'b1, 8'd2, 1'b0, 8'd0, 1'b1, 1'b0, 8'd2};
        vecs[1] = '{1'b1, 8'd3, 1'b1, 8'd4, 1'b0, 1'b1, 8'd4};
        vecs[2] = '{1'b1, 8'd5, 1'b1, 8'd6, 1'b1, 1'b0, 8'd5};
        vecs[3] = '{1'b0, 8'd7, 1'b0, 8'd8, 1'b0, 1'b0, 8'd5};
        vecs[4] = '{1'b0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1, 8'd1};
        vecs[5] = '{1'b1, 8'd9, 1'b1, 8'd7, 1'b1, 1'b0, 8'd9};

        // Reset state, then default 10-cycle half period
        do_reset();
        chk("reset oclk", oclk, 0);
        chk("reset tick", tick, 0);
        chk("reset active_half", active_half, 9);
        chk("reset pending", pending, 0);
        run = 1'b1;
        step();
        chk("run entry oclk", oclk, 0);
        wait_oclk(1'b1, n, stray);
        chk("first rise delay", n, 10);
        chk("first rise tick", tick, 1);
        wait_oclk(1'b0, n, stray);
        chk("fall tick", tick, 1);
        wait_oclk(1'b1, n2, stray);
        chk("default period", n + n2, 20);
        chk("stray ticks", stray, 0);
        step();
        chk("tick one cycle", tick, 0);

        // Arbitration and update in STOP, table driven
        do_reset();
        foreach (vecs[i]) begin
            a_valid = vecs[i].av; a_half = vecs[i].ah;
            b_valid = vecs[i].bv; b_half = vecs[i].bh;
            #1;
            chk($sformatf("vec%0d a_ready", i), a_ready, vecs[i].exp_ar);
            chk($sformatf("vec%0d b_ready", i), b_ready, vecs[i].exp_br);
            step();
            chk($sformatf("vec%0d active_half", i), active_half, vecs[i].exp_active);
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // STOP update to half=2, then 6-cycle period
        do_reset();
        a_valid = 1'b1; a_half = 8'd2;
        #1;
        chk("stop a_ready", a_ready, 1);
        step();
        a_valid = 1'b0;
        chk("stop active_half", active_half, 2);
        run = 1'b1;
        step();
        wait_oclk(1'b1, n, stray);
        chk("half2 first rise", n, 3);
        wait_oclk(1'b0, n, stray);
        wait_oclk(1'b1, n2, stray);
        chk("half2 period", n + n2, 6);

        // Update in RUN at cnt=3 takes effect at the next TC
        do_reset();
        run = 1'b1;
        step();
        wait_oclk(1'b1, n, stray);
        step(); step(); step();
        b_valid = 1'b1; b_half = 8'd4;
        #1;
        chk("run b_ready", b_ready, 1);
        step();
        b_valid = 1'b0;
        chk("run pending set", pending, 1);
        chk("run active held", active_half, 9);
        wait_oclk(1'b0, n, stray);
        chk("old phase length", n + 4, 10);
        chk("pending cleared", pending, 0);
        chk("new active_half", active_half, 4);
        wait_oclk(1'b1, n, stray);
        chk("new phase length", n, 5);

        // Round robin with both requesters in RUN
        do_reset();
        run = 1'b1;
        step();
        a_valid = 1'b1; a_half = 8'd3; b_valid = 1'b1; b_half = 8'd5;
        #1;
        chk("tie1 a_ready", a_ready, 1);
        chk("tie1 b_ready", b_ready, 0);
        step();
        a_valid = 1'b0;
        viol = 0; n = 0;
        while (pending === 1'b1 && n < 40) begin
            if (b_ready !== 1'b0) viol++;
            step();
            n++;
        end
        chk("b_ready low in PEND", viol, 0);
        chk("b granted after PEND", b_ready, 1);
        chk("a value applied", active_half, 3);
        step();
        b_valid = 1'b0;
        chk("b pending", pending, 1);
        n = 0;
        while (pending === 1'b1 && n < 40) begin step(); n++; end
        chk("b value applied", active_half, 5);
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk("tie2 a_ready", a_ready, 1);
        chk("tie2 b_ready", b_ready, 0);
        step();
        a_valid = 1'b0; b_valid = 1'b0;

        // Stop while high finishes the phase; stop while low is immediate
        do_reset();
        run = 1'b1;
        step();
        wait_oclk(1'b1, n, stray);
        step(); step();
        run = 1'b0;
        wait_oclk(1'b0, n, stray);
        chk("high stop fall delay", n, 8);
        chk("high stop tick", tick, 1);
        step();
        chk("stopped tick", tick, 0);
        chk("stopped oclk", oclk, 0);
        run = 1'b1;
        step();
        wait_oclk(1'b1, n, stray);
        chk("restart from cnt0", n, 10);
        wait_oclk(1'b0, n, stray);
        step(); step();
        run = 1'b0;
        step();
        chk("low stop tick", tick, 0);
        chk("low stop oclk", oclk, 0);
        run = 1'b1;
        step();
        wait_oclk(1'b1, n, stray);
        chk("low stop cnt cleared", n, 10);

        // Reset while PEND discards the pending value
        do_reset();
        a_valid = 1'b1; a_half = 8'd2;
        step();
        a_valid = 1'b0;
        run = 1'b1;
        step();
        a_valid = 1'b1; a_half = 8'd7;
        #1;
        chk("pre-reset a_ready", a_ready, 1);
        step();
        a_valid = 1'b0;
        chk("pre-reset pending", pending, 1);
        run = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid reset oclk", oclk, 0);
        chk("mid reset tick", tick, 0);
        chk("mid reset pending", pending, 0);
        chk("mid reset active_half", active_half, 9);
        a_valid = 1'b1; a_half = 8'd4;
        step();
        a_valid = 1'b0;
        chk("post reset in STOP", pending, 0);
        chk("post reset update", active_half, 4);

        // Randomized traffic against the reference model
        do_reset();
        m_run_mode = 0; m_has_pend = 0; m_oclk = 0; m_tick = 0; m_last_b = 1;
        m_cnt = 0; m_pend = 0; m_active = 9;
        for (int c = 0; c < 3000; c++) begin
            if (!a_valid && $urandom_range(0, 99) < 30) begin
                a_valid = 1'b1; a_half = CW'($urandom_range(0, 4));
            end
            if (!b_valid && $urandom_range(0, 99) < 30) begin
                b_valid = 1'b1; b_half = CW'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 99) < 4) run = !run;
            #1;
            ga = !m_has_pend && a_valid && (!b_valid || m_last_b);
            gb = !m_has_pend && b_valid && !(a_valid && (!b_valid || m_last_b));
            gval = ga ? int'(a_half) : int'(b_half);
            chk("rand a_ready", a_ready, ga);
            chk("rand b_ready", b_ready, gb);
            model_cycle(run, ga, gb, gval);
            step();
            chk("rand oclk", oclk, m_oclk);
            chk("rand tick", tick, m_tick);
            chk("rand active_half", active_half, m_active);
            chk("rand pending", pending, m_has_pend);
            if (ga) a_valid = 1'b0;
            if (gb) b_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
